airi5c_lzc_pipe: RTL and testbench

AIRI5C_LZC_PIPE -- requirements
Module: airi5c_lzc_pipe

---
 rtl/airi5c_lzc_pkg.sv | 24 ++
 rtl/airi5c_lzc_group.sv | 28 ++
 rtl/airi5c_lzc_pipe.sv | 142 ++++++++++++++
 tb/tb_airi5c_lzc_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/airi5c_lzc_pkg.sv
// ============================================================================
// Module : airi5c_lzc_pkg
// Brief  : Shared count-mode encodings and count-width helper for LZC users.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package airi5c_lzc_pkg;

    typedef enum logic [1:0] {
        LZC_LZ  = 2'b00,
        LZC_LO  = 2'b01,
        LZC_TZ  = 2'b10,
        LZC_RSV = 2'b11
    } lzc_mode_e;

    // Count must be able to represent WIDTH itself (all-zero operand).
    function automatic int lzc_cw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/airi5c_lzc_group.sv
// ============================================================================
// Module : airi5c_lzc_group
// Brief  : Leading-zero count of one 4-bit group plus its all-zero flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module airi5c_lzc_group (
    input  logic [3:0] nib,
    output logic [1:0] cnt,
    output logic       zero
);

    always_comb begin
        cnt  = 2'd0;
        zero = (nib == 4'b0000);
        casez (nib)
            4'b1???: cnt = 2'd0;
            4'b01??: cnt = 2'd1;
            4'b001?: cnt = 2'd2;
            4'b0001: cnt = 2'd3;
            default: cnt = 2'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/airi5c_lzc_pipe.sv
// ============================================================================
// Module : airi5c_lzc_pipe
// Brief  : Two-stage leading-zero/one and trailing-zero counter with normaliser.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module airi5c_lzc_pipe
    import airi5c_lzc_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CW    = lzc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0]     w_rev;
    logic [WIDTH-1:0]     w_xform;
    logic [NG-1:0][1:0]   w_grp_cnt;
    logic [NG-1:0]        w_grp_zero;
    logic [CW-1:0]        w_count;
    logic                 w_zero;
    logic [WIDTH-1:0]     w_norm;
    logic                 w_adv1;
    logic                 w_adv2;
    logic                 w_take_in;
    logic                 w_load2;

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_data;
    lzc_mode_e            r_s1_mode;
    logic [NG-1:0][1:0]   r_s1_grp_cnt;
    logic [NG-1:0]        r_s1_grp_zero;
    logic                 r_out_valid;
    logic [CW-1:0]        r_out_count;
    logic                 r_out_zero;
    logic [WIDTH-1:0]     r_out_norm;

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rev[i] = in_data[WIDTH-1-i];
        end
        case (lzc_mode_e'(in_mode))
            LZC_LO:  w_xform = ~in_data;
            LZC_TZ:  w_xform = w_rev;
            default: w_xform = in_data;
        endcase
    end

    // Group 0 is the most significant nibble.
    for (genvar g = 0; g < NG; g++) begin : g_grp
        airi5c_lzc_group u_grp (
            .nib  (w_xform[WIDTH-1-4*g -: 4]),
            .cnt  (w_grp_cnt[g]),
            .zero (w_grp_zero[g])
        );
    end

    // Scan from the LSB group upward so the most significant non-zero group wins.
    always_comb begin
        w_count = CW'(WIDTH);
        for (int g = NG - 1; g >= 0; g--) begin
            if (!r_s1_grp_zero[g]) begin
                w_count = CW'(4 * g) + CW'(r_s1_grp_cnt[g]);
            end
        end
        w_zero = &r_s1_grp_zero;
        if (w_zero) begin
            w_norm = '0;
        end else if (r_s1_mode == LZC_TZ) begin
            w_norm = r_s1_data >> w_count;
        end else begin
            w_norm = r_s1_data << w_count;
        end
    end

    assign w_adv2    = !r_out_valid || out_ready;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign w_take_in = in_valid && w_adv1 && !kill;
    assign w_load2   = r_s1_valid && w_adv2 && !kill;
    assign in_ready  = w_adv1;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (kill) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_adv1) r_s1_valid  <= in_valid;
            if (w_adv2) r_out_valid <= r_s1_valid;
        end
    end

    // Data only moves with a real transfer, so idle outputs stay at their reset value.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_s1_data     <= '0;
            r_s1_mode     <= LZC_LZ;
            r_s1_grp_cnt  <= '0;
            r_s1_grp_zero <= '0;
            r_out_count   <= '0;
            r_out_zero    <= 1'b0;
            r_out_norm    <= '0;
        end else begin
            if (w_take_in) begin
                r_s1_data     <= in_data;
                r_s1_mode     <= lzc_mode_e'(in_mode);
                r_s1_grp_cnt  <= w_grp_cnt;
                r_s1_grp_zero <= w_grp_zero;
            end
            if (w_load2) begin
                r_out_count <= w_count;
                r_out_zero  <= w_zero;
                r_out_norm  <= w_norm;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign out_zero  = r_out_zero;
    assign out_norm  = r_out_norm;

endmodule

`default_nettype wire

// File: tb/tb_airi5c_lzc_pipe.sv
// ============================================================================
// Module : tb_airi5c_lzc_pipe
// Brief  : Directed and randomized scoreboard bench for airi5c_lzc_pipe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_airi5c_lzc_pipe;

    localparam int WIDTH = 32;
    localparam int CW    = 6;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic             kill = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       in_mode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    out_count;
    logic             out_zero;
    logic [WIDTH-1:0] out_norm;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cnt;
        logic        z;
        logic [31:0] n;
    } res_t;

    res_t exp_q[$];

    logic          prev_stall = 1'b0;
    logic          prev_kill  = 1'b0;
    logic [CW-1:0] hold_cnt;
    logic          hold_zero;
    logic [31:0]   hold_norm;

    airi5c_lzc_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .kill      (kill),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero),
        .out_norm  (out_norm)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: count from the MSB of the transformed operand, bit by bit.
    function automatic res_t model(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] t;
        res_t        r;
        for (int i = 0; i < 32; i++) t[i] = d[31-i];
        if (m == 2'b01)      t = ~d;
        else if (m != 2'b10) t = d;
        r.cnt = 32;
        for (int i = 31; i >= 0; i--) begin
            if (t[i]) begin
                r.cnt = 31 - i;
                break;
            end
        end
        r.z = (r.cnt == 32);
        r.n = r.z ? 32'h0 : ((m == 2'b10) ? (d >> r.cnt) : (d << r.cnt));
        return r;
    endfunction

    task automatic single(input string tag, input logic [31:0] d, input logic [1:0] m,
                          input int ecnt, input logic ez, input logic [31:0] enorm);
        in_data   = d;
        in_mode   = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_val({tag, "_rdy"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check_val({tag, "_v_early"}, out_valid, 0);
        step();
        @(negedge clk);
        check_val({tag, "_valid"}, out_valid, 1);
        check_val({tag, "_count"}, out_count, ecnt);
        check_val({tag, "_zero"}, out_zero, ez);
        check_val({tag, "_norm"}, out_norm, enorm);
        step();
        @(negedge clk);
        check_val({tag, "_v_after"}, out_valid, 0);
        step();
    endtask

    task automatic rnd_cycle(input bit drain);
        logic [31:0] d;
        int          sh;
        res_t        e;
        if (drain) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            kill      = 1'b0;
        end else begin
            sh = $urandom_range(0, 32);
            d  = (sh == 32) ? 32'h0 : ($urandom >> sh);
            if ($urandom % 2) d = ~d;
            in_data   = d;
            in_mode   = 2'($urandom % 4);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            kill      = ($urandom % 50) == 0;
        end
        @(negedge clk);
        if (prev_stall && !prev_kill) begin
            check_val("hold_valid", out_valid, 1);
            check_val("hold_count", out_count, hold_cnt);
            check_val("hold_zero", out_zero, hold_zero);
            check_val("hold_norm", out_norm, hold_norm);
        end
        prev_stall = out_valid && !out_ready;
        prev_kill  = kill;
        hold_cnt   = out_count;
        hold_zero  = out_zero;
        hold_norm  = out_norm;
        if (kill) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("rnd_unexpected", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rnd_count", out_count, e.cnt);
                    check_val("rnd_zero", out_zero, e.z);
                    check_val("rnd_norm", out_norm, e.n);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode));
        end
        step();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_count", out_count, 0);
        check_val("rst_zero", out_zero, 0);
        check_val("rst_norm", out_norm, 0);
        step();
        n_reset = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);
        step();

        // Spot values
        single("lz_15", 32'h0001_0000, 2'b00, 15, 1'b0, 32'h8000_0000);
        single("lz_all0", 32'h0000_0000, 2'b00, 32, 1'b1, 32'h0);
        single("lo_all1", 32'hFFFF_FFFF, 2'b01, 32, 1'b1, 32'h0);
        single("lo_24", 32'hFFFF_FF00, 2'b01, 24, 1'b0, 32'h0);
        single("tz_9", 32'h0000_0A00, 2'b10, 9, 1'b0, 32'h0000_0005);
        single("m11_lz", 32'h0000_0300, 2'b11, 22, 1'b0, 32'hC000_0000);
        single("lz_0", 32'h8000_0001, 2'b00, 0, 1'b0, 32'h8000_0001);

        // Backpressure: three operands, out_ready low for 5 cycles
        out_ready = 1'b0;
        in_mode   = 2'b00;
        in_valid  = 1'b1;
        in_data   = 32'h0001_0000;
        @(negedge clk);
        check_val("bp_rdy_a", in_ready, 1);
        step();
        in_data = 32'h0000_0100;
        @(negedge clk);
        check_val("bp_rdy_b", in_ready, 1);
        step();
        in_data = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_rdy_drop", in_ready, 0);
            check_val("bp_stall_valid", out_valid, 1);
            check_val("bp_stall_count", out_count, 15);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_rdy_c", in_ready, 1);
        check_val("bp_out_a", out_count, 15);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check_val("bp_v_b", out_valid, 1);
        check_val("bp_out_b", out_count, 23);
        step();
        @(negedge clk);
        check_val("bp_v_c", out_valid, 1);
        check_val("bp_out_c", out_count, 0);
        step();
        @(negedge clk);
        check_val("bp_empty", out_valid, 0);
        step();

        // Kill with both stages full, operand offered in the kill cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001;
        step();
        in_data = 32'h0000_0002;
        step();
        in_data = 32'h0000_0004;
        kill    = 1'b1;
        @(negedge clk);
        check_val("kill_full", out_valid, 1);
        step();
        kill     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("kill_ov", out_valid, 0);
        check_val("kill_rdy", in_ready, 1);
        step();
        single("kill_next", 32'h0000_0F00, 2'b00, 20, 1'b0, 32'hF000_0000);

        // Asynchronous reset between edges with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_00FF;
        step();
        in_data = 32'h0000_F000;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check_val("arst_full", out_valid, 1);
        #2;
        n_reset = 1'b0;
        #1;
        check_val("arst_valid", out_valid, 0);
        check_val("arst_count", out_count, 0);
        check_val("arst_norm", out_norm, 0);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        #1;
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check_val("arst_post_valid", out_valid, 0);
            check_val("arst_post_count", out_count, 0);
            check_val("arst_post_zero", out_zero, 0);
            check_val("arst_post_norm", out_norm, 0);
            check_val("arst_post_rdy", in_ready, 1);
        end
        step();
        single("arst_next", 32'h0000_0040, 2'b00, 25, 1'b0, 32'h8000_0000);

        // Randomized traffic against the scoreboard
        exp_q.delete();
        for (int c = 0; c < 600; c++) rnd_cycle(1'b0);
        for (int c = 0; c < 6; c++) rnd_cycle(1'b1);
        check_val("rnd_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
